// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_busy;
    logic [ID_W-1:0]              grant_id;
    logic                         locked;
    logic                         err_timeout;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, locked, err_timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, locked, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter feeding bytes from several requesters
// into a single UART transmitter, with a watchdog on the transmitter's busy response.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ID_W:0]    NUM_W    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [ID_W-1:0]      rr_ptr_reg;
    logic [ID_W-1:0]      grant_id_reg;
    logic                 locked_reg;
    logic [DATA_BITS-1:0] tx_data_reg;
    logic [CNT_W-1:0]     cnt_reg;

    logic [ID_W-1:0]      rot_idx  [NUM_REQ];
    logic [DATA_BITS-1:0] data_arr [NUM_REQ];
    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic                 xfer;
    logic                 timeout;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (v == LAST_ID) ? '0 : v + 1'b1;
    endfunction

    // rot_idx[k] is the requester visited k steps after rr_ptr in the search order.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [ID_W:0] rot_sum;
            logic [ID_W:0] rot_wrap;
            assign rot_sum      = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign rot_wrap     = rot_sum - NUM_W;
            assign rot_idx[gi]  = (rot_sum >= NUM_W) ? rot_wrap[ID_W-1:0] : rot_sum[ID_W-1:0];
            assign data_arr[gi] = bus.req_data[gi*DATA_BITS +: DATA_BITS];
            assign bus.req_ready[gi] = xfer && (win_idx == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = grant_id_reg;
        if (locked_reg) begin
            win_found = bus.req_valid[grant_id_reg];
        end else begin
            // Descending scan so the closest valid requester to rr_ptr is kept last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[rot_idx[k]]) begin
                    win_found = 1'b1;
                    win_idx   = rot_idx[k];
                end
            end
        end
    end

    assign xfer = (state_reg == IDLE) && win_found;

    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        case (state_reg)
            IDLE:      if (xfer) state_next = ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: if (!bus.tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            locked_reg   <= 1'b0;
            tx_data_reg  <= '0;
            cnt_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (xfer) begin
                tx_data_reg  <= data_arr[win_idx];
                grant_id_reg <= win_idx;
                locked_reg   <= !bus.req_last[win_idx];
                if (bus.req_last[win_idx]) begin
                    rr_ptr_reg <= wrap_inc(win_idx);
                end
            end
            if (timeout) begin
                locked_reg <= 1'b0;
                rr_ptr_reg <= wrap_inc(grant_id_reg);
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= '0;
            end else if (state_reg == WAIT_BUSY && !bus.tx_busy && !timeout) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.tx_start    = (state_reg == ISSUE);
    assign bus.tx_data     = tx_data_reg;
    assign bus.grant_id    = grant_id_reg;
    assign bus.locked      = locked_reg;
    assign bus.err_timeout = timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a queue-based
// model of requester packets, round-robin order and packet locking.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int QD = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_BITS(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .ACK_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    logic [8:0] fifo [N][QD];
    int   wr_p [N];
    int   rd_p [N];
    bit   hold [N];
    int   m_rr, m_owner;
    bit   m_locked;
    bit   fast_expected;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit last);
        fifo[i][wr_p[i] % QD] = {last, d};
        wr_p[i]++;
    endtask

    task automatic push_pkt(input int i, input int len);
        for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
    endtask

    function automatic bit avail(input int i);
        return (wr_p[i] != rd_p[i]) && !hold[i];
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (wr_p[i] != rd_p[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Model: locked owner is the only candidate, else first available from rr.
    function automatic int predict();
        if (m_locked) return avail(m_owner) ? m_owner : -1;
        for (int k = 0; k < N; k++) if (avail((m_rr + k) % N)) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic drive_reqs();
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*DW-1:0] d;
        logic [8:0]      h;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            h = fifo[i][rd_p[i] % QD];
            v[i] = avail(i);
            l[i] = h[8];
            d[i*DW +: DW] = h[7:0];
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        check({tag, "_grant_id"}, 32'(bus.grant_id), 0);
        check({tag, "_locked"}, 32'(bus.locked), 0);
        check({tag, "_err_timeout"}, 32'(bus.err_timeout), 0);
    endtask

    // Waits for the arbiter to accept, checks the winner, ends at the ISSUE negedge.
    task automatic xfer(output logic [7:0] data);
        int w, n;
        logic [8:0] h;
        data = '0;
        drive_reqs();
        #1;
        w = predict();
        if (w < 0) begin
            n_err++;
            $error("FAIL no_candidate: observed=none expected=a valid requester");
            return;
        end
        n = 0;
        while (bus.req_ready == '0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (fast_expected) check("idle_latency", 32'(n), 0);
        fast_expected = 1'b0;
        check("req_ready_winner", 32'(bus.req_ready), 32'(1) << w);
        h = fifo[w][rd_p[w] % QD];
        data = h[7:0];
        @(posedge clk);
        #1;
        rd_p[w]++;
        m_owner  = w;
        m_locked = !h[8];
        if (h[8]) m_rr = (w + 1) % N;
        drive_reqs();
        @(negedge clk);
        check("tx_start_pulse", 32'(bus.tx_start), 1);
        check("tx_data", 32'(bus.tx_data), 32'(h[7:0]));
        check("grant_id", 32'(bus.grant_id), 32'(w));
        check("locked", 32'(bus.locked), 32'(m_locked));
        check("ready_low_issue", 32'(bus.req_ready), 0);
        $display("xfer req=%0d data=%02h last=%0b locked=%0b", w, h[7:0], h[8], m_locked);
    endtask

    task automatic finish_byte(input int busy_len, input logic [7:0] data);
        int n;
        if (busy_len > 0) begin
            bus.tx_busy = 1'b1;
            for (int c = 0; c < busy_len; c++) begin
                @(negedge clk);
                check("busy_tx_start_low", 32'(bus.tx_start), 0);
                check("busy_ready_low", 32'(bus.req_ready), 0);
                check("busy_data_stable", 32'(bus.tx_data), 32'(data));
                check("busy_no_err", 32'(bus.err_timeout), 0);
            end
            bus.tx_busy = 1'b0;
            @(negedge clk);
        end else begin
            n = 0;
            while (!bus.err_timeout && n < TO + 8) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", 32'(n), 32'(TO));
            $display("timeout req=%0d after %0d cycles", m_owner, n);
            m_locked = 1'b0;
            m_rr     = (m_owner + 1) % N;
            @(negedge clk);
            check("timeout_err_single", 32'(bus.err_timeout), 0);
            check("timeout_unlocked", 32'(bus.locked), 0);
        end
        fast_expected = 1'b1;
    endtask

    task automatic serve(input int busy_len);
        logic [7:0] d;
        xfer(d);
        finish_byte(busy_len, d);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (pending() && guard < 200) begin
            serve(2);
            guard++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        bus.tx_busy   = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            wr_p[i] = 0; rd_p[i] = 0; hold[i] = 1'b0;
        end
        m_rr = 0; m_owner = 0; m_locked = 1'b0; fast_expected = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single-byte packet from requester 0
        push(0, 8'h55, 1'b1);
        serve(3);

        // All requesters valid with single-byte packets: rotation
        for (int i = 0; i < N; i++) begin
            push(i, 8'(8'h10 + i), 1'b1);
            push(i, 8'(8'h20 + i), 1'b1);
        end
        for (int k = 0; k < 5; k++) serve(10);
        drain();

        // 3-byte locked packet from requester 2 while requester 1 keeps requesting
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        serve(2);
        for (int k = 0; k < 3; k++) push(1, 8'(8'hB0 + k), 1'b1);
        serve(2);
        // Owner drops valid: nobody else may be granted
        hold[2] = 1'b1;
        drive_reqs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_ready_low", 32'(bus.req_ready), 0);
            check("hold_locked", 32'(bus.locked), 1);
        end
        hold[2] = 1'b0;
        fast_expected = 1'b0;
        serve(2);
        serve(2);
        drain();

        // Transmitter never goes busy on the first byte of a 2-byte packet
        push_pkt(3, 2);
        push(0, 8'hC0, 1'b1);
        fast_expected = 1'b0;
        serve(0);
        serve(2);
        drain();

        // Asynchronous reset during WAIT_DONE of a locked packet
        push_pkt(3, 3);
        fast_expected = 1'b0;
        xfer(d);
        bus.tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_locked", 32'(bus.locked), 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        $display("reset asserted mid-frame at %0t", $time);
        m_rr = 0; m_owner = 0; m_locked = 1'b0;
        bus.tx_busy = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        push(0, 8'hD0, 1'b1);
        push(2, 8'hD2, 1'b1);
        serve(2);
        drain();

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            int busy;
            if (predict() < 0) push_pkt($urandom_range(0, N - 1), $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) push_pkt($urandom_range(0, N - 1), $urandom_range(1, 3));
            busy = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 6);
            serve(busy);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, byte width.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 16, the maximum number of cycles to wait for tx_busy after tx_start.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, per-requester byte available.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_BITS, with requester i's byte at bits [i*DATA_BITS +: DATA_BITS].
REQ-008 The block SHALL have port req_last, input, NUM_REQ, marking the offered byte as the final byte of its packet.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ, per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 The block SHALL have port tx_start, output, 1, a 1-cycle pulse that launches the transmitter.
REQ-011 The block SHALL have port tx_data, output, DATA_BITS, the byte for the transmitter, stable from tx_start until return to IDLE.
REQ-012 The block SHALL have port tx_busy, input, 1, transmitter busy (high for the full frame).
REQ-013 The block SHALL have port grant_id, output, clog2(NUM_REQ), the index of the current or last granted requester.
REQ-014 The block SHALL have port locked, output, 1, high while a packet is in progress (owner holds the grant).
REQ-015 The block SHALL have port err_timeout, output, 1, a 1-cycle pulse when tx_busy fails to rise within ACK_TIMEOUT cycles.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-017 In IDLE with locked=0, the winner SHALL be the first requester with req_valid=1, searching from rr_ptr upward modulo NUM_REQ.
REQ-018 In IDLE with locked=1, the only candidate SHALL be grant_id; other requesters SHALL wait even if valid.
REQ-019 req_ready SHALL be combinational: req_ready[i]=1 only in IDLE, for the candidate/winner i, when req_valid[i]=1; at most one bit of req_ready SHALL be high, and outside IDLE it SHALL be all zero.
REQ-020 On a transfer:
- req_data[i] SHALL be registered into tx_data.
- grant_id SHALL be set to i.
- locked SHALL be set to !req_last[i].
- The FSM SHALL go to ISSUE.
REQ-021 In ISSUE, tx_start SHALL be 1 for exactly one cycle, giving a latency of 1 cycle from transfer to tx_start; the FSM SHALL then go to WAIT_BUSY and clear the timeout counter.
REQ-022 In WAIT_BUSY:
- tx_busy=1 SHALL move the FSM to WAIT_DONE.
- Otherwise the counter SHALL increment.
- When the counter reaches ACK_TIMEOUT-1 with tx_busy still 0, the block SHALL pulse err_timeout, clear locked, and return to IDLE.
REQ-023 In WAIT_DONE, tx_busy=0 SHALL return the FSM to IDLE; there is no timeout in this state.
REQ-024 rr_ptr SHALL update to (grant_id+1) mod NUM_REQ only when a packet ends, i.e. a transfer with req_last=1 or an err_timeout.
REQ-025 rr_ptr SHALL be unchanged by a mid-packet byte.
REQ-026 Lock semantics:
- A locked owner that drops req_valid SHALL keep the grant indefinitely.
- The arbiter SHALL not preempt it.
REQ-027 A transfer of a single-byte packet (req_last=1 on the first byte) SHALL leave locked at 0.
REQ-028 If tx_busy is already 1 during ISSUE, WAIT_BUSY SHALL exit to WAIT_DONE on its first cycle.
REQ-029 Back-to-back operation:
- The next transfer SHALL be possible in the first IDLE cycle after WAIT_DONE exits.
- The minimum period SHALL be 4 cycles plus the tx_busy duration.
REQ-030 Unused or illegal FSM encodings SHALL return to IDLE on the next clock.

Reset
REQ-031 Assertion of rst SHALL immediately, without waiting for clk, force:
- state=IDLE
- rr_ptr=0, grant_id=0
- locked=0
- tx_start=0, tx_data=0
- err_timeout=0
- timeout counter=0
REQ-032 Reset asserted mid-frame SHALL abandon the byte without an error pulse; the transmitter is not informed.
REQ-033 After rst deasserts, the first transfer SHALL occur on the first IDLE cycle in which a requester is valid.

Verification
REQ-034 Reset, then req_valid=4'b0001 with data 0x55 and last=1 -> req_ready[0] high 1 cycle; tx_start the next cycle with tx_data=0x55; locked stays 0; rr_ptr=1.
REQ-035 All four requesters valid, every byte last=1, tx model busy for 10 cycles -> grants in order 0,1,2,3,0; each tx_start occurs 1 cycle after its transfer.
REQ-036 Requester 2 sends a 3-byte packet (A1,A2,A3, last on A3) while requester 1 is continuously valid -> tx_data sequence A1,A2,A3 uninterrupted; locked=1 after A1 and A2; requester 1 is granted next.
REQ-037 tx model never asserts tx_busy -> err_timeout pulses exactly ACK_TIMEOUT cycles after tx_start; locked clears; rr_ptr advances; the next requester is served.
REQ-038 rst asserted between clock edges during WAIT_DONE of a locked packet -> all outputs reach reset values before the next edge; after release, arbitration restarts from requester 0.
